instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter DEPTH, default 4, prefetch FIFO entries, power of two, 2..16.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 memAddr  out  32  instruction address to memory port A.
REQ-006 memEn  out  1  port A request strobe, one request per cycle high.
REQ-007 memReady  in  1  memory accepts a request this cycle.
REQ-008 memData  in  32  returned instruction word.
REQ-009 memValid  in  1  memData valid; responses in request order, latency >=1 cycle.
REQ-010 redirect  in  1  flush and restart fetch at redirectPc.
REQ-011 redirectPc  in  32  new fetch PC.
REQ-012 instrValid  out  1  FIFO head valid toward decode.
REQ-013 instr  out  32  FIFO head instruction.
REQ-014 instrPc  out  32  FIFO head PC.
REQ-015 instrReady  in  1  decode consumes head when instrValid && instrReady.
REQ-016 misalign  out  1  registered pulse, redirectPc[1:0] != 0 at redirect.

Function
REQ-017 Request issued when memEn && memReady; memAddr = fetchPc; fetchPc += 4 same edge.
REQ-018 memEn SHALL be high only if (occupancy + outstanding) < DEPTH and no redirect this cycle.
REQ-019 Each valid response writes {fetchPc-of-request, memData} to FIFO tail; PC tracked by in-order PC tag queue.
REQ-020 Combinational output: instr/instrPc/instrValid from FIFO head, no bubble when FIFO non-empty.
REQ-021 Simultaneous push and pop with FIFO full SHALL succeed (credit rule REQ-018 prevents overflow).
REQ-022 fetchPc, read/write pointers wrap modulo 2^32 and modulo DEPTH respectively.
REQ-023 redirect: FIFO emptied, instrValid low next cycle, fetchPc <= {redirectPc[31:2],2'b00}, dropCnt <= outstanding minus any response arriving that cycle.
REQ-024 While dropCnt != 0, memValid responses discarded, dropCnt decremented; fetch of new PC may issue concurrently.
REQ-025 Redirect during drop: dropCnt recomputed per REQ-023; no stale word ever reaches decode.
REQ-026 States: RUN (issuing), FULL (credits exhausted), DRAIN (dropCnt != 0); DRAIN->RUN when dropCnt reaches 0; RUN<->FULL on credit availability.
REQ-027 memValid with zero outstanding SHALL be ignored.

Reset
REQ-028 On reset: fetchPc = RESET_PC, FIFO empty, outstanding = 0, dropCnt = 0, state RUN.
REQ-029 Reset outputs: memEn 0, memAddr RESET_PC, instrValid 0, instr 0, instrPc 0, misalign 0.
REQ-030 First request issued first cycle after reset deassertion with memReady high.

Configuration
REQ-031 Macro IFETCH_PERF_CNT_EN defined: extra output stallCnt (32 bits, reset 0) increments each cycle instrReady && !instrValid, saturating at 32'hFFFF_FFFF.
REQ-032 Macro undefined: no stallCnt port, no counter logic.

Structure
REQ-033 Shared package fetch_pkg: XLEN=32, INSTR_BYTES=4, typedef fetch_entry_t {pc, instr}, NOP encoding 32'h0000_0013.
REQ-034 One sub-module fetch_fifo (parameterised DEPTH, fetch_entry_t, flush input); PC tag queue reuses it.

Verification
REQ-035 Reset, memReady=1, latency 1, instrReady=1 -> memAddr 0,4,8,...; instrPc 0,4,8 on consecutive cycles.
REQ-036 instrReady=0, DEPTH=4 -> exactly 4 requests issued, then memEn 0 until a pop.
REQ-037 Latency 3, 2 outstanding, redirect to 32'h100 -> two stale responses dropped, first instrPc 32'h100.
REQ-038 Redirect to 32'h102 -> misalign pulse 1 cycle, fetch at 32'h100.
REQ-039 fetchPc 32'hFFFF_FFFC -> next request 32'h0000_0000.
REQ-040 IFETCH_PERF_CNT_EN, memReady=0 for 10 cycles with instrReady=1 -> stallCnt = 10.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: definitions shared by the instruction fetch unit and its FIFOs.
//   XLEN          machine word / address width
//   INSTR_BYTES   fetch stride in bytes
//   NOP           canonical no-op encoding (addi x0,x0,0)
//   fetch_entry_t {pc, instr} pair held by the prefetch FIFO and the PC tag queue
//   fetch_state_t fetch control states
//   alignPc()     clears the byte-offset bits of a fetch address
package fetch_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // RUN: issuing requests, FULL: no credits left, DRAIN: discarding stale responses
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry FIFO of fetch_entry_t with combinational head read.
// Used both as the prefetch buffer and as the in-order PC tag queue.
// Ports:
//   clk, reset   clock, asynchronous active-high reset
//   flush        empties the FIFO; wins over push/pop in the same cycle
//   push, pushData  write at tail (accepted when not full, or when full with pop)
//   pop          remove head (ignored when empty)
//   headData     current head entry (meaningless while empty)
//   empty, count occupancy status
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             pushData,
  input  logic                     pop,
  output fetch_entry_t             headData,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wrPtr;
  logic [AW-1:0]  rdPtr;
  logic           doPush;
  logic           doPop;

  // A full FIFO still takes a push when the head leaves in the same cycle:
  // the tail slot being written is the head slot being read out.
  assign doPop  = pop && (count != '0);
  assign doPush = push && ((count != FULL_CNT) || doPop);

  assign empty    = (count == '0);
  assign headData = mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + AW'(1);
      if (doPop)  rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: in-order instruction prefetcher with redirect support.
// Optional feature: define IFETCH_PERF_CNT_EN to add the stallCnt output.
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   memAddr/memEn/memReady       request port (request accepted when memEn && memReady)
//   memData/memValid             in-order responses, latency >= 1
//   redirect/redirectPc          flush and restart fetch at redirectPc (word aligned)
//   instrValid/instr/instrPc     prefetch FIFO head toward decode
//   instrReady                   decode consumes head when instrValid && instrReady
//   misalign                     one-cycle pulse after a redirect to an unaligned PC
//   stallCnt (optional)          cycles with decode ready but nothing to give it
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] memAddr,
  output logic        memEn,
  input  logic        memReady,
  input  logic [31:0] memData,
  input  logic        memValid,
  input  logic        redirect,
  input  logic [31:0] redirectPc,
  output logic        instrValid,
  output logic [31:0] instr,
  output logic [31:0] instrPc,
  input  logic        instrReady,
  output logic        misalign
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0] stallCnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;
  localparam int DW = 8;
  localparam logic [SW-1:0] CREDITS = SW'(DEPTH);

  fetch_state_t    state;
  fetch_state_t    stateNext;
  logic [XLEN-1:0] fetchPc;
  logic [DW-1:0]   dropCnt;
  logic [DW-1:0]   dropNext;
  logic [DW-1:0]   inflight;

  fetch_entry_t    fifoHead;
  fetch_entry_t    tagHead;
  logic            fifoEmpty;
  logic            tagEmpty;
  logic [CW-1:0]   fifoCount;
  logic [CW-1:0]   tagCount;

  logic [SW-1:0]   used;
  logic [SW-1:0]   usedNext;
  logic            issue;
  logic            popFire;
  logic            respKeep;
  logic            unusedTagInstr;

  assign used    = SW'(fifoCount) + SW'(tagCount);
  assign memEn   = !reset && !redirect && (used < CREDITS);
  assign memAddr = fetchPc;
  assign issue   = memEn && memReady;

  assign instrValid = !fifoEmpty;
  assign instr      = instrValid ? fifoHead.instr : '0;
  assign instrPc    = instrValid ? fifoHead.pc    : '0;
  assign popFire    = instrValid && instrReady;

  // A response is kept only when it belongs to a live request: not while
  // stale responses are still owed, not during a redirect, and never when
  // no request is outstanding.
  assign respKeep = memValid && !redirect && (state != DRAIN) && !tagEmpty;

  assign unusedTagInstr = ^tagHead.instr;

  fetch_fifo #(.DEPTH(DEPTH)) uPrefetch (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push     (respKeep),
    .pushData ('{pc: tagHead.pc, instr: memData}),
    .pop      (popFire),
    .headData (fifoHead),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  fetch_fifo #(.DEPTH(DEPTH)) uPcTags (
    .clk      (clk),
    .reset    (reset),
    .flush    (redirect),
    .push     (issue),
    .pushData ('{pc: fetchPc, instr: NOP}),
    .pop      (respKeep),
    .headData (tagHead),
    .empty    (tagEmpty),
    .count    (tagCount)
  );

  // Every request not yet answered is either owed as a drop or still tagged.
  // On redirect all of them become drops, minus one answered this very cycle.
  assign inflight = dropCnt + DW'(tagCount);

  always_comb begin
    dropNext = dropCnt;
    if (redirect) begin
      dropNext = inflight - DW'(memValid && (inflight != '0));
    end else if (memValid && (dropCnt != '0)) begin
      dropNext = dropCnt - DW'(1);
    end
  end

  // Moving a response from tag queue to prefetch FIFO leaves the credit
  // total unchanged, so only issues and pops alter it.
  always_comb begin
    usedNext = '0;
    if (!redirect) usedNext = used + SW'(issue) - SW'(popFire);
    stateNext = RUN;
    if (dropNext != '0)           stateNext = DRAIN;
    else if (usedNext >= CREDITS) stateNext = FULL;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      fetchPc  <= RESET_PC;
      dropCnt  <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= stateNext;
      dropCnt  <= dropNext;
      misalign <= redirect && (redirectPc[1:0] != 2'b00);
      if (redirect)   fetchPc <= alignPc(redirectPc);
      else if (issue) fetchPc <= fetchPc + XLEN'(INSTR_BYTES);
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  // Counts decode-starved cycles, holding at the maximum value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stallCnt <= '0;
    end else if (instrReady && !instrValid && (stallCnt != 32'hFFFF_FFFF)) begin
      stallCnt <= stallCnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch. A memory model answers
// accepted requests after memLat cycles with data ~addr; the driver pushes the
// hand-computed PCs decode must see into expQ; a monitor pops and compares.
module tb_instr_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] memAddr;
  logic        memEn;
  logic        memReady;
  logic [31:0] memData;
  logic        memValid;
  logic        redirect;
  logic [31:0] redirectPc;
  logic        instrValid;
  logic [31:0] instr;
  logic [31:0] instrPc;
  logic        instrReady;
  logic        misalign;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] stallCnt;
`endif

  int          checks;
  int          errors;
  int          cycle;
  int          memLat;
  bit          strayPulse;
  int          reqCount;
  logic [31:0] expQ[$];
  logic [31:0] pendAddr[$];
  int          pendDue[$];

  instr_fetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .memAddr    (memAddr),
    .memEn      (memEn),
    .memReady   (memReady),
    .memData    (memData),
    .memValid   (memValid),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .instrValid (instrValid),
    .instr      (instr),
    .instrPc    (instrPc),
    .instrReady (instrReady),
    .misalign   (misalign)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .stallCnt   (stallCnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are settled 2 time units later.
  task automatic applyStimulus(input logic mr, input logic ir, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    memReady   = mr;
    instrReady = ir;
    redirect   = rd;
    redirectPc = rpc;
    #2;
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (expQ.size() == 0 && pendAddr.size() == 0 && !instrValid) break;
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    end
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  task automatic memoryLoop();
    forever begin
      @(negedge clk);
      cycle++;
      #1;
      if (strayPulse) begin
        memValid = 1'b1;
        memData  = 32'hDEAD_BEEF;
      end else if (pendAddr.size() > 0 && pendDue[0] <= cycle) begin
        memValid = 1'b1;
        memData  = ~pendAddr[0];
        void'(pendAddr.pop_front());
        void'(pendDue.pop_front());
      end else begin
        memValid = 1'b0;
        memData  = 32'h0;
      end
      if (!reset && memEn && memReady) begin
        pendAddr.push_back(memAddr);
        pendDue.push_back(cycle + memLat);
      end
    end
  endtask

  task automatic monitorLoop();
    logic [31:0] e;
    forever begin
      @(negedge clk);
      #3;
      if (!reset && instrValid && instrReady) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_pop actual_pc=%h required=none", instrPc);
        end else begin
          e = expQ.pop_front();
          checkOutput("instrPc", instrPc, e);
          checkOutput("instr", instr, ~e);
        end
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; cycle = 0; memLat = 1; strayPulse = 1'b0;
    reset = 1'b1; memReady = 1'b0; instrReady = 1'b0;
    redirect = 1'b0; redirectPc = 32'h0; memValid = 1'b0; memData = 32'h0;
    fork
      memoryLoop();
      monitorLoop();
    join_none

    // Reset values
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_memEn", 32'(memEn), 32'd0);
    checkOutput("rst_memAddr", memAddr, 32'h0);
    checkOutput("rst_instrValid", 32'(instrValid), 32'd0);
    checkOutput("rst_instr", instr, 32'h0);
    checkOutput("rst_instrPc", instrPc, 32'h0);
    checkOutput("rst_misalign", 32'(misalign), 32'd0);

    // Idle with decode ready: ten starved cycles
    @(negedge clk);
    reset = 1'b0;
    instrReady = 1'b1;
    #2;
    repeat (10) applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
`ifdef IFETCH_PERF_CNT_EN
    checkOutput("stallCnt", stallCnt, 32'd10);
`endif

    // Streaming at latency 1
    memLat = 1;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
      checkOutput("stream_memEn", 32'(memEn), 32'd1);
      checkOutput("stream_memAddr", memAddr, 32'(i * 4));
      if (i >= 2) checkOutput("stream_instrValid", 32'(instrValid), 32'd1);
      expQ.push_back(32'(i * 4));
    end
    waitDrain("stream_drain");

    // Decode stalled: credits allow exactly four requests
    reqCount = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      if (memEn && memReady) reqCount++;
    end
    checkOutput("credit_reqs", 32'(reqCount), 32'd4);
    expQ.push_back(32'h20); expQ.push_back(32'h24);
    expQ.push_back(32'h28); expQ.push_back(32'h2C);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
    checkOutput("credit_full_memEn", 32'(memEn), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("credit_freed_memEn", 32'(memEn), 32'd1);
    waitDrain("credit_drain");

    // Latency 3, redirect with two requests outstanding
    memLat = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("lat3_memAddr", memAddr, 32'h30);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h100);
    checkOutput("redir_memEn", 32'(memEn), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir_memAddr", memAddr, 32'h100);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    expQ.push_back(32'h100); expQ.push_back(32'h104); expQ.push_back(32'h108);
    waitDrain("drop_drain");

    // Misaligned redirect with a non-empty FIFO and a response in flight
    memLat = 1;
    repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h102);
    checkOutput("pre_flush_valid", 32'(instrValid), 32'd1);
    checkOutput("pre_misalign", 32'(misalign), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("flush_valid", 32'(instrValid), 32'd0);
    checkOutput("misalign_pulse", 32'(misalign), 32'd1);
    checkOutput("misalign_memAddr", memAddr, 32'h100);
    checkOutput("misalign_memEn", 32'(memEn), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("misalign_clear", 32'(misalign), 32'd0);
    checkOutput("misalign_next", memAddr, 32'h104);
    expQ.push_back(32'h100); expQ.push_back(32'h104);
    waitDrain("misalign_drain");

    // PC wrap
    applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_top", memAddr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("wrap_zero", memAddr, 32'h0);
    expQ.push_back(32'hFFFF_FFFC); expQ.push_back(32'h0);
    waitDrain("wrap_drain");

    // Response with nothing outstanding is ignored
    strayPulse = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    strayPulse = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("stray_ignored", 32'(instrValid), 32'd0);

    // Second redirect while still dropping
    memLat = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("drain_issue", memAddr, 32'h200);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h300);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("redir2_memAddr", memAddr, 32'h300);
    expQ.push_back(32'h300);
    waitDrain("redir2_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
